// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath stages (pooling, fully-connected).
package cnn_pkg;

  // Default pixel width and feature-map geometry of the network.
  localparam int PIX_W   = 32;
  localparam int FM_IN   = 24;
  localparam int FM_POOL = 12;

  typedef logic signed [PIX_W-1:0] pix_t;

  // Signed maximum; on a tie both operands are identical.
  function automatic pix_t smax(input pix_t a, input pix_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pool_line_buf.sv
// Half-line buffer holding the horizontal maxima of the even input row.
// Combinational read and synchronous write share one index.
module pool_line_buf #(
  parameter int DEPTH = 12,
  parameter int W     = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [DEPTH];

  // Store one horizontal pair maximum per accepted odd-column even-row pixel.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/pool_stream.sv
// Streaming 2x2 stride-2 signed max-pool over a raster-ordered frame.
// The output register is a one-deep skid: when it is full and not being
// drained, all input is stalled.
module pool_stream
  import cnn_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int IMG_W  = FM_IN,
  parameter int IMG_H  = FM_IN
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              frame_done
);

  localparam int CW    = $clog2(IMG_W);
  localparam int RW    = $clog2(IMG_H);
  localparam int LB_D  = IMG_W / 2;
  localparam int LB_AW = (LB_D > 1) ? $clog2(LB_D) : 1;

  if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_w
    $error("pool_stream: IMG_W must be even and >= 2");
  end
  if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_h
    $error("pool_stream: IMG_H must be even and >= 2");
  end

  // Signed maximum at the module's own pixel width.
  function automatic logic [DATA_W-1:0] wmax(input logic [DATA_W-1:0] a,
                                             input logic [DATA_W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  logic [CW-1:0]     col_reg;
  logic [RW-1:0]     row_reg;
  logic [DATA_W-1:0] h_reg;
  logic [DATA_W-1:0] out_data_reg;
  logic              out_valid_reg;
  logic              out_last_reg;
  logic              frame_done_reg;

  logic              accept;
  logic              col_last;
  logic              row_last;
  logic              lb_we;
  logic              load;
  logic [LB_AW-1:0]  lb_addr;
  logic [DATA_W-1:0] lb_rdata;
  logic [DATA_W-1:0] pair_max;
  logic [DATA_W-1:0] win_max;

  assign in_ready = ~out_valid_reg | out_ready;
  assign accept   = in_valid & in_ready & ~clear;
  assign col_last = (col_reg == CW'(IMG_W - 1));
  assign row_last = (row_reg == RW'(IMG_H - 1));
  assign lb_addr  = LB_AW'(col_reg >> 1);
  assign pair_max = wmax(h_reg, in_data);
  assign win_max  = wmax(lb_rdata, pair_max);
  // Even row, odd column: park the pair maximum for the next row.
  assign lb_we    = accept & ~row_reg[0] & col_reg[0];
  // Odd row, odd column: the 2x2 window is complete.
  assign load     = accept & row_reg[0] & col_reg[0];

  pool_line_buf #(
    .DEPTH (LB_D),
    .W     (DATA_W),
    .AW    (LB_AW)
  ) u_lb (
    .clk   (clk),
    .we    (lb_we),
    .addr  (lb_addr),
    .wdata (pair_max),
    .rdata (lb_rdata)
  );

  // Left pixel of each horizontal pair; deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept && !col_reg[0]) h_reg <= in_data;
  end

  // Raster position, output register and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_reg        <= '0;
      row_reg        <= '0;
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else if (clear) begin
      col_reg        <= '0;
      row_reg        <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= out_valid_reg & out_ready & out_last_reg;
      if (accept) begin
        if (col_last) begin
          col_reg <= '0;
          row_reg <= row_last ? '0 : row_reg + 1'b1;
        end else begin
          col_reg <= col_reg + 1'b1;
        end
      end
      if (load) begin
        out_data_reg  <= win_max;
        out_valid_reg <= 1'b1;
        out_last_reg  <= row_last & col_last;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_data   = out_data_reg;
  assign out_last   = out_last_reg;
  assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_pool_stream.sv
// Self-checking bench for pool_stream: window table, ramp frames,
// backpressure, clear, asynchronous reset and randomised back-to-back frames.
module tb_pool_stream;

  localparam int W = 24;
  localparam int H = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        frame_done;

  pool_stream dut (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  typedef struct {
    logic [31:0] p00;
    logic [31:0] p01;
    logic [31:0] p10;
    logic [31:0] p11;
    logic [31:0] exp;
  } win_t;

  int n_checks = 0;
  int n_pass   = 0;

  exp_t exp_q[$];
  logic signed [31:0] fm [H][W];
  int   m_row = 0;
  int   m_col = 0;
  logic fd_pending  = 1'b0;
  logic pushed_prev = 1'b0;
  logic strict      = 1'b0;
  logic ramp_mode   = 1'b0;
  int   ramp_idx    = 0;
  int   fd_count    = 0;
  int   n_out       = 0;
  logic [31:0] last_pop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
  endtask

  // Reference: keep the whole frame, take the max of the 4 stored pixels.
  task automatic model_accept(input logic [31:0] d, output logic pushed);
    exp_t e;
    logic signed [31:0] best;
    pushed = 1'b0;
    fm[m_row][m_col] = d;
    if ((m_row % 2 == 1) && (m_col % 2 == 1)) begin
      best = fm[m_row-1][m_col-1];
      for (int dr = 0; dr < 2; dr++)
        for (int dc = 0; dc < 2; dc++)
          if (fm[m_row-1+dr][m_col-1+dc] > best) best = fm[m_row-1+dr][m_col-1+dc];
      e.data = best;
      e.last = (m_row == H-1) && (m_col == W-1);
      exp_q.push_back(e);
      pushed = 1'b1;
    end
    if (m_col == W-1) begin
      m_col = 0;
      m_row = (m_row == H-1) ? 0 : m_row + 1;
    end else begin
      m_col++;
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_row = 0;
    m_col = 0;
    fd_pending  = 1'b0;
    pushed_prev = 1'b0;
    ramp_idx    = 0;
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later.
  task automatic step(input logic iv, input logic [31:0] d, input logic ordy,
                      input logic clr, output logic took);
    exp_t e;
    logic exp_fd;
    logic pushed;
    int   rr, rc;
    @(negedge clk);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    clear     = clr;
    #1;
    exp_fd = fd_pending;
    fd_pending = 1'b0;
    if (frame_done || exp_fd) chk("frame_done", {31'd0, frame_done}, {31'd0, exp_fd});
    if (frame_done) fd_count++;
    if (strict && (out_valid || pushed_prev))
      chk("latency_out_valid", {31'd0, out_valid}, {31'd0, pushed_prev});
    if (out_valid && ordy && !clr) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL spurious_output: got 0x%08h required no output", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", out_data, e.data);
        chk("out_last", {31'd0, out_last}, {31'd0, e.last});
        if (e.last) fd_pending = 1'b1;
      end
      if (ramp_mode) begin
        rr = ramp_idx / 12;
        rc = ramp_idx % 12;
        chk("ramp_data", out_data, 32'((2*rr+1)*24 + 2*rc + 1));
        chk("ramp_last", {31'd0, out_last}, {31'd0, ramp_idx == 143});
        ramp_idx++;
      end
      last_pop = out_data;
      n_out++;
    end
    took = iv && in_ready && !clr;
    pushed = 1'b0;
    if (took) model_accept(d, pushed);
    pushed_prev = pushed;
    if (clr) model_reset();
  endtask

  // mode: 0 = out_ready low, 1 = out_ready high, 2 = random out_ready and gaps.
  task automatic send(input logic [31:0] d, input int mode);
    logic took;
    logic ordy;
    int   tries;
    if (mode == 2 && $urandom_range(0, 3) == 0) begin
      step(1'b0, $urandom, 1'($urandom_range(0, 1)), 1'b0, took);
    end
    tries = 0;
    took  = 1'b0;
    while (!took && tries < 200) begin
      ordy = (mode == 2) ? 1'($urandom_range(0, 1)) : (mode == 1);
      step(1'b1, d, ordy, 1'b0, took);
      tries++;
    end
    if (!took) begin
      n_checks++;
      $display("FAIL send_timeout: got in_ready=0 for 200 cycles required acceptance");
    end
  endtask

  task automatic ramp_range(input int first, input int last_i, input int mode);
    for (int i = first; i <= last_i; i++) send(32'(i), mode);
  endtask

  task automatic drain();
    logic took;
    int   n;
    n = 0;
    while (exp_q.size() > 0 && n < 200) begin
      step(1'b0, 32'd0, 1'b1, 1'b0, took);
      n++;
    end
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d outputs pending required 0", exp_q.size());
    end
    step(1'b0, 32'd0, 1'b1, 1'b0, took);
    step(1'b0, 32'd0, 1'b1, 1'b0, took);
  endtask

  task automatic do_clear();
    logic took;
    step(1'b0, 32'd0, 1'b0, 1'b1, took);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    win_t wins [8];
    logic took;
    logic [31:0] held_data;
    logic        held_last;
    int fd0, out0;

    wins[0] = '{32'hFFFF_FFFB, 32'hFFFF_FFFD, 32'hFFFF_FFF7, 32'hFFFF_FFF9, 32'hFFFF_FFFD};
    wins[1] = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd4};
    wins[2] = '{32'd4, 32'd3, 32'd2, 32'd1, 32'd4};
    wins[3] = '{32'h8000_0000, 32'h8000_0001, 32'h8000_0000, 32'h8000_0000, 32'h8000_0001};
    wins[4] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h7FFF_FFFF};
    wins[5] = '{32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFFF};
    wins[6] = '{32'h8000_0000, 32'd0, 32'h8000_0000, 32'h8000_0000, 32'd0};
    wins[7] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFE};

    rst = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_out_data", out_data, 32'd0);
    chk("reset_out_last", {31'd0, out_last}, 32'd0);
    chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b1;

    // Full ramp frame with continuous flow and exact latency.
    strict = 1'b1; ramp_mode = 1'b1; ramp_idx = 0;
    fd0 = fd_count;
    ramp_range(0, W*H-1, 1);
    drain();
    chk("ramp_count", 32'(ramp_idx), 32'd144);
    chk("ramp_frame_done_pulses", 32'(fd_count - fd0), 32'd1);
    strict = 1'b0; ramp_mode = 1'b0;

    // Window table: each window at the top-left of a freshly cleared frame.
    for (int i = 0; i < 8; i++) begin
      do_clear();
      send(wins[i].p00, 1);
      send(wins[i].p01, 1);
      for (int c = 2; c < W; c++) send(32'd0, 1);
      send(wins[i].p10, 1);
      send(wins[i].p11, 1);
      step(1'b0, 32'd0, 1'b1, 1'b0, took);
      chk($sformatf("window[%0d]", i), last_pop, wins[i].exp);
    end

    // Backpressure: hold out_ready low for 10 cycles with a result pending.
    do_clear();
    ramp_mode = 1'b1; ramp_idx = 0;
    ramp_range(0, W+1, 0);
    step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, took);
    held_data = out_data;
    held_last = out_last;
    chk("hold_first_value", held_data, 32'd25);
    for (int i = 0; i < 10; i++) begin
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_out_data", out_data, held_data);
      chk("hold_out_last", {31'd0, out_last}, {31'd0, held_last});
      if (i < 9) step(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, took);
    end
    fd0 = fd_count;
    ramp_range(W+2, W*H-1, 1);
    drain();
    chk("hold_ramp_count", 32'(ramp_idx), 32'd144);
    chk("hold_frame_done_pulses", 32'(fd_count - fd0), 32'd1);
    ramp_mode = 1'b0;

    // Clear at (7,13) with a pending result, then a fresh ramp frame.
    do_clear();
    ramp_mode = 1'b1; ramp_idx = 0;
    ramp_range(0, 7*W+13, 1);
    step(1'b1, 32'h1234_5678, 1'b0, 1'b1, took);
    chk("clear_pending_valid", {31'd0, out_valid}, 32'd1);
    step(1'b0, 32'd0, 1'b1, 1'b0, took);
    chk("clear_out_valid", {31'd0, out_valid}, 32'd0);
    chk("clear_out_last", {31'd0, out_last}, 32'd0);
    fd0 = fd_count;
    ramp_range(0, W*H-1, 1);
    drain();
    chk("clear_ramp_count", 32'(ramp_idx), 32'd144);
    chk("clear_frame_done_pulses", 32'(fd_count - fd0), 32'd1);

    // Asynchronous reset mid-frame at (11,5), then a full ramp frame.
    ramp_idx = 0;
    ramp_range(0, 11*W+5, 1);
    @(posedge clk);
    #2;
    chk("pre_reset_out_valid", {31'd0, out_valid}, 32'd1);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_out_data", out_data, 32'd0);
    chk("async_rst_out_last", {31'd0, out_last}, 32'd0);
    chk("async_rst_frame_done", {31'd0, frame_done}, 32'd0);
    chk("async_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    fd0 = fd_count;
    ramp_range(0, W*H-1, 1);
    drain();
    chk("rst_ramp_count", 32'(ramp_idx), 32'd144);
    chk("rst_frame_done_pulses", 32'(fd_count - fd0), 32'd1);
    ramp_mode = 1'b0;

    // Two back-to-back random frames with random gaps and backpressure.
    do_clear();
    fd0  = fd_count;
    out0 = n_out;
    for (int i = 0; i < 2*W*H; i++) send($urandom, 2);
    drain();
    chk("random_output_count", 32'(n_out - out0), 32'd288);
    chk("random_frame_done_pulses", 32'(fd_count - fd0), 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
